zxw_matmul_ctrl: RTL and testbench

//  Sequencer for the lab matrix-multiply datapath: computes C = A x B (NxN) by driving operand

---
 rtl/zxw_matmul_pkg.sv | 18 +
 rtl/zxw_idx_counter.sv | 34 +++
 rtl/zxw_matmul_ctrl.sv | 97 +++++++++
 tb/tb_zxw_matmul_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/zxw_matmul_pkg.sv
// zxw_matmul_pkg: state encoding and default geometry for the matrix-multiply sequencer
package zxw_matmul_pkg;
    localparam int N_DEF  = 4;
    localparam int AW_DEF = 5;
    localparam int CW_DEF = 4;
    localparam int B_BASE = N_DEF * N_DEF;

    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t FETCH = 3'd1;
    localparam state_t DRAIN = 3'd2;
    localparam state_t WRITE = 3'd3;
    localparam state_t DONE  = 3'd4;

    function automatic int b_base(input int n);
        return n * n;
    endfunction
endpackage

// File: rtl/zxw_idx_counter.sv
// zxw_idx_counter: nested i/j/k element counter; k walks the dot product, j/i walk result elements
module zxw_idx_counter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_k,
    input  logic          inc_ij,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic [IW-1:0] k,
    output logic          last_k,
    output logic          last_ij
);
    localparam logic [IW-1:0] MAX = IW'(N - 1);

    assign last_k  = k == MAX;
    assign last_ij = i == MAX && j == MAX;

    // k advances every fetch cycle; j advances per written element and carries into i
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else begin
            if (inc_k) k <= last_k ? '0 : k + 1'b1;
            if (inc_ij) begin
                j <= j == MAX ? '0 : j + 1'b1;
                if (j == MAX) i <= i == MAX ? '0 : i + 1'b1;
            end
        end
endmodule

// File: rtl/zxw_matmul_ctrl.sv
// zxw_matmul_ctrl: C = A x B sequencer driving operand reads, MAC controls, result writes and display address.
// Optional SW_SYNC_EN: double-flop the switch input before the display mux (3-cycle display latency).
module zxw_matmul_ctrl
    import zxw_matmul_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    input  logic [4:0]    SW_in,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          wr_en,
    output logic [CW-1:0] wr_addr,
    output logic [4:0]    disp_addr,
    output logic          busy,
    output logic          done
);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam int BB = b_base(N);

    state_t        state, state_nx;
    logic          start_q, start_edge, fetch;
    logic          last_k, last_ij;
    logic [IW-1:0] i, j, k;
    logic [4:0]    sw;

    zxw_idx_counter #(.N(N), .IW(IW)) u_idx (
        .clk    (Clock),
        .rst_n  (Resetn),
        .inc_k  (fetch),
        .inc_ij (wr_en),
        .i      (i),
        .j      (j),
        .k      (k),
        .last_k (last_k),
        .last_ij(last_ij)
    );

    assign start_edge = Start & ~start_q;
    assign fetch      = state == FETCH;
    assign wr_en      = state == WRITE;
    assign done       = state == DONE;
    assign busy       = fetch || state == DRAIN || wr_en;
    assign rd_addr_a  = fetch ? AW'(int'(i) * N + int'(k)) : '0;
    assign rd_addr_b  = fetch ? AW'(BB + int'(k) * N + int'(j)) : '0;
    assign wr_addr    = wr_en ? CW'(int'(i) * N + int'(j)) : '0;

    // next state; Start edges are only honoured from IDLE, so DONE always falls back to IDLE
    always_comb
        state_nx = state == IDLE  ? (start_edge ? FETCH : IDLE) :
                   state == FETCH ? (last_k ? DRAIN : FETCH) :
                   state == DRAIN ? WRITE :
                   state == WRITE ? (last_ij ? DONE : FETCH) : IDLE;

    // state, Start history and MAC controls trailing the fetch by the 1-cycle memory latency
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            state   <= IDLE;
            start_q <= 1'b0;
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
        end else begin
            state   <= state_nx;
            start_q <= Start;
            mac_en  <= fetch;
            mac_clr <= fetch && k == '0;
        end

`ifdef SW_SYNC_EN
    logic [4:0] sw_s1, sw_s2;

    // two-flop synchronizer for the asynchronous switch bank
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= SW_in;
            sw_s2 <= sw_s1;
        end

    assign sw = sw_s2;
`else
    assign sw = SW_in;
`endif

    // display follows the switches when idle and freezes while the result memory is being written
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) disp_addr <= '0;
        else if (!busy) disp_addr <= sw;
endmodule

// File: tb/tb_zxw_matmul_ctrl.sv
// tb_zxw_matmul_ctrl: directed self-checking bench for the matmul sequencer (N=4, AW=5, CW=4)
module tb_zxw_matmul_ctrl;
`ifdef SW_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 0, rst_n = 0, start = 0;
    logic [4:0] sw = 5'd1;
    logic [4:0] rd_a, rd_b, disp;
    logic [3:0] wr_addr;
    logic       mac_clr, mac_en, wr_en, busy, done;
    int         n_chk = 0, n_err = 0, n_wr, n_done;
    wire [23:0] outs = {busy, mac_clr, mac_en, wr_en, done, wr_addr, rd_a, rd_b, disp};

    always #5 clk = ~clk;

    zxw_matmul_ctrl dut (
        .Clock    (clk),
        .Resetn   (rst_n),
        .Start    (start),
        .SW_in    (sw),
        .rd_addr_a(rd_a),
        .rd_addr_b(rd_b),
        .mac_clr  (mac_clr),
        .mac_en   (mac_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .disp_addr(disp),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    // walks the 96 busy cycles from the first FETCH, ends on the DONE cycle
    task automatic run_check(input logic [4:0] dexp, input logic [4:0] sw_busy, input int st_at);
        int e, c, i, j;
        logic [23:0] got, exp;
        for (int t = 0; t < 96; t++) begin
            e = t / 6;
            c = t % 6;
            i = e / 4;
            j = e % 4;
            got = {busy, mac_clr, mac_en, wr_en, done, c == 5 ? wr_addr : 4'd0,
                   c < 4 ? rd_a : 5'd0, c < 4 ? rd_b : 5'd0, disp};
            exp = {1'b1, c == 1, c >= 1 && c <= 4, c == 5, 1'b0, c == 5 ? 4'(e) : 4'd0,
                   c < 4 ? 5'(i * 4 + c) : 5'd0, c < 4 ? 5'(16 + c * 4 + j) : 5'd0, dexp};
            chk($sformatf("run t=%0d", t), 32'(got), 32'(exp));
            if (t == 0) sw = sw_busy;
            if (t == st_at) start = 1;
            if (t == st_at + 2) start = 0;
            @(negedge clk);
        end
        chk("done cycle", 32'({busy, mac_clr, mac_en, wr_en, done, disp}), 32'({5'b00001, dexp}));
    endtask

    initial begin
        repeat (10) @(negedge clk);
        chk("reset outputs", 32'(outs), 32'd0);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("idle disp", 32'(disp), 32'd1);
        chk("idle busy", 32'(busy), 32'd0);

        pulse_start();
        run_check(5'd1, 5'd1, -1);
        @(negedge clk);
        chk("idle after run", 32'({busy, done, wr_en}), 32'd0);

        start = 1;
        n_wr = 0;
        n_done = 0;
        repeat (200) begin
            @(negedge clk);
            n_wr += int'(wr_en);
            n_done += int'(done);
        end
        chk("held start writes", 32'(n_wr), 32'd16);
        chk("held start dones", 32'(n_done), 32'd1);
        start = 0;
        @(negedge clk);

        chk("disp before switch", 32'(disp), 32'd1);
        sw = 5'b10011;
        repeat (LAT - 1) @(negedge clk);
        chk("disp latency-1", 32'(disp), 32'd1);
        @(negedge clk);
        chk("disp latency", 32'(disp), 32'd19);
        pulse_start();
        run_check(5'd19, 5'd7, -1);
        repeat (LAT + 1) @(negedge clk);
        chk("disp after run", 32'(disp), 32'd7);

        pulse_start();
        repeat (40) @(negedge clk);
        rst_n = 0;
        #1;
        chk("abort outputs", 32'(outs), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort no write", 32'(wr_en), 32'd0);
        end
        rst_n = 1;
        repeat (4) @(negedge clk);
        pulse_start();
        run_check(5'd7, 5'd7, -1);

        start = 1;
        repeat (5) begin
            @(negedge clk);
            chk("start at done ignored", 32'(busy), 32'd0);
        end
        start = 0;
        @(negedge clk);
        pulse_start();
        run_check(5'd7, 5'd7, 20);
        @(negedge clk);
        pulse_start();
        run_check(5'd7, 5'd7, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
